cmp_cascade_counter: RTL and testbench



---
 rtl/cmp_cascade_pkg.sv | 34 +++
 rtl/cmp_cascade_counter_if.sv | 57 +++++
 rtl/cmp_counter_digit.sv | 75 +++++++
 rtl/cmp_cascade_counter.sv | 120 ++++++++++++
 tb/tb_cmp_cascade_counter.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/cmp_cascade_pkg.sv
// ---------------------------------------------------------------------------
// cmp_cascade_pkg
//
// Shared definitions for the cascaded digit counter / comparator.
//
// Contents:
//   cmp_mode_e   - encoding of the CMP_MODE bus field (EQ, GE, LE, OFF)
//   clamp_digit  - limits a raw digit value to the largest legal digit
//
// The package has no ports. The digit width is fixed only when a design
// instantiates the counter, so clamp_digit works on 32-bit unsigned values.
// The caller widens its digit on the way in and narrows the result on the
// way out.
// ---------------------------------------------------------------------------
package cmp_cascade_pkg;

  // Compare-mode encoding. The values match the two-bit CMP_MODE field.
  // MODE_OFF forces the compare result low.
  typedef enum logic [1:0] {
    MODE_EQ  = 2'b00,
    MODE_GE  = 2'b01,
    MODE_LE  = 2'b10,
    MODE_OFF = 2'b11
  } cmp_mode_e;

  // Returns d when it is a legal digit. Otherwise returns dmax.
  // A BCD counter (dmax = 9) that is loaded with 0xA..0xF therefore
  // lands on 9 and never enters an illegal code.
  function automatic int unsigned clamp_digit(input int unsigned d,
                                              input int unsigned dmax);
    return (d > dmax) ? dmax : d;
  endfunction

endpackage

// File: rtl/cmp_cascade_counter_if.sv
// ---------------------------------------------------------------------------
// cmp_cascade_counter_if
//
// Groups the control, compare and status signals of cmp_cascade_counter.
// The clock and reset stay outside the interface and are plain ports of
// the counter.
//
// Parameter:
//   W         packed count width (DIGIT_W * DIGITS of the counter)
//
// Signals (driven by the master, i.e. the pattern source):
//   EN        count enable
//   UP        1 = count up, 0 = count down
//   LD        parallel load
//   LD_VAL    load value, digit 0 in the low bits
//   CMP       compare value, same packing as LD_VAL
//   CMP_MODE  compare mode (see cmp_cascade_pkg::cmp_mode_e)
//   CLR_HIT   clears the sticky HIT flag
//
// Signals (driven by the slave, i.e. the counter):
//   Q         current count
//   Z         combinational compare result
//   TC        combinational terminal count
//   WRAP      registered wrap pulse
//   HIT       registered sticky compare flag
// ---------------------------------------------------------------------------
interface cmp_cascade_counter_if #(
  parameter int W = 16
);

  logic         EN;
  logic         UP;
  logic         LD;
  logic [W-1:0] LD_VAL;
  logic [W-1:0] CMP;
  logic [1:0]   CMP_MODE;
  logic         CLR_HIT;

  logic [W-1:0] Q;
  logic         Z;
  logic         TC;
  logic         WRAP;
  logic         HIT;

  // Stimulus side: drives the controls and observes the status.
  modport master (
    output EN, UP, LD, LD_VAL, CMP, CMP_MODE, CLR_HIT,
    input  Q, Z, TC, WRAP, HIT
  );

  // Counter side: consumes the controls and produces the status.
  modport slave (
    input  EN, UP, LD, LD_VAL, CMP, CMP_MODE, CLR_HIT,
    output Q, Z, TC, WRAP, HIT
  );

endinterface

// File: rtl/cmp_counter_digit.sv
// ---------------------------------------------------------------------------
// cmp_counter_digit
//
// One digit of the cascaded counter. The digit counts modulo DIGIT_MAX+1
// in either direction. It only moves when the enable is set and every
// lower digit sits at its terminal value, which the carry input signals.
//
// Parameters:
//   DIGIT_W    bits in the digit
//   DIGIT_MAX  largest digit value (must be < 2**DIGIT_W)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   load       parallel load (wins over counting)
//   load_val   raw load value, clamped to DIGIT_MAX before it is stored
//   en         count enable
//   up         1 = count up, 0 = count down
//   carry_in   all lower digits are terminal (tie high for digit 0)
//   value      current digit value
//   term       digit is terminal for the current direction
//              (== DIGIT_MAX when counting up, == 0 when counting down)
// ---------------------------------------------------------------------------
module cmp_counter_digit
  import cmp_cascade_pkg::*;
#(
  parameter int          DIGIT_W   = 4,
  parameter int unsigned DIGIT_MAX = (1 << DIGIT_W) - 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               en,
  input  logic               up,
  input  logic               carry_in,
  output logic [DIGIT_W-1:0] value,
  output logic               term
);

  localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(DIGIT_MAX);

  logic               at_max;
  logic               at_zero;
  logic [DIGIT_W-1:0] load_digit;

  // The end-of-range detectors are shared between the roll-over logic
  // and the terminal flag. The terminal flag picks whichever end matches
  // the current direction, because that end makes the next digit up
  // move on this edge.
  always_comb begin
    at_max     = (value == MAX_D);
    at_zero    = (value == '0);
    term       = up ? at_max : at_zero;
    load_digit = DIGIT_W'(clamp_digit(32'(load_val), DIGIT_MAX));
  end

  // The digit register resolves reset first, then load, then counting.
  // When counting, the digit rolls over at either end so that it stays
  // inside 0..DIGIT_MAX. The digit holds whenever the carry input is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_digit;
    end else if (en && carry_in) begin
      if (up) begin
        value <= at_max ? '0 : value + DIGIT_W'(1);
      end else begin
        value <= at_zero ? MAX_D : value - DIGIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cmp_cascade_counter.sv
// ---------------------------------------------------------------------------
// cmp_cascade_counter
//
// Cascaded digit counter with a programmable comparator. DIGITS copies of
// cmp_counter_digit are chained so that each digit advances only when all
// lower digits are terminal. This gives a binary counter (DIGIT_MAX =
// 2**DIGIT_W-1) or a BCD counter (DIGIT_MAX = 9) from the same code.
//
// Parameters:
//   DIGIT_W    bits per digit
//   DIGITS     number of cascaded digits, W = DIGIT_W*DIGITS
//   DIGIT_MAX  largest digit value (must be < 2**DIGIT_W)
//
// Ports:
//   CK         clock, rising edge
//   RSTN       synchronous active-low reset
//   bus        cmp_cascade_counter_if slave modport:
//                EN, UP, LD, LD_VAL, CMP, CMP_MODE, CLR_HIT in
//                Q, Z, TC, WRAP, HIT out
// ---------------------------------------------------------------------------
module cmp_cascade_counter
  import cmp_cascade_pkg::*;
#(
  parameter int          DIGIT_W   = 4,
  parameter int          DIGITS    = 4,
  parameter int unsigned DIGIT_MAX = (1 << DIGIT_W) - 1
) (
  input logic                  CK,
  input logic                  RSTN,
  cmp_cascade_counter_if.slave bus
);

  localparam int W = DIGIT_W * DIGITS;

  logic [W-1:0]    q;
  logic [DIGITS-1:0] term;
  // carry[k] is high when every digit below k is terminal.
  // carry[DIGITS] therefore means that the whole counter is terminal.
  logic [DIGITS:0] carry;
  logic            tc;
  logic            z;
  logic            wrap_q;
  logic            hit_q;

  assign carry[0] = 1'b1;

  // Build the digit chain. Every digit sees the same load/enable/direction.
  // Only the carry input differs between digits. Each carry input ANDs
  // the terminal flags of all lower digits, so the chain ripples from
  // digit 0 upwards.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    cmp_counter_digit #(
      .DIGIT_W   (DIGIT_W),
      .DIGIT_MAX (DIGIT_MAX)
    ) u_digit (
      .clk      (CK),
      .rst_n    (RSTN),
      .load     (bus.LD),
      .load_val (bus.LD_VAL[k*DIGIT_W +: DIGIT_W]),
      .en       (bus.EN),
      .up       (bus.UP),
      .carry_in (carry[k]),
      .value    (q[k*DIGIT_W +: DIGIT_W]),
      .term     (term[k])
    );

    assign carry[k+1] = carry[k] & term[k];
  end

  // TC means that the next enabled edge will wrap the whole counter.
  // It is gated by EN, so a stalled counter never reports a terminal count.
  always_comb begin
    tc = bus.EN & carry[DIGITS];
  end

  // The comparator works on the packed value. The most significant digit
  // sits in the top bits, so a plain unsigned compare orders BCD and
  // binary counts correctly. Out-of-range CMP digits are compared as raw
  // bits and are not clamped.
  always_comb begin
    z = 1'b0;
    case (cmp_mode_e'(bus.CMP_MODE))
      MODE_EQ:  z = (q == bus.CMP);
      MODE_GE:  z = (q >= bus.CMP);
      MODE_LE:  z = (q <= bus.CMP);
      MODE_OFF: z = 1'b0;
      default:  z = 1'b0;
    endcase
  end

  // WRAP marks the cycle in which Q holds a freshly wrapped value. It is
  // set only by a real count step taken from the terminal value. A load
  // overrides counting on its edge, so a load cycle never produces WRAP,
  // even when TC was high. HIT is sticky. A compare match on this edge
  // beats a clear request, so no match is lost when the two arrive on
  // the same edge.
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      wrap_q <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      wrap_q <= tc & ~bus.LD;
      if (z) begin
        hit_q <= 1'b1;
      end else if (bus.CLR_HIT) begin
        hit_q <= 1'b0;
      end
    end
  end

  // Drive the status signals back onto the bus.
  always_comb begin
    bus.Q    = q;
    bus.Z    = z;
    bus.TC   = tc;
    bus.WRAP = wrap_q;
    bus.HIT  = hit_q;
  end

endmodule

// File: tb/tb_cmp_cascade_counter.sv
// ---------------------------------------------------------------------------
// tb_cmp_cascade_counter
//
// Self-checking bench for cmp_cascade_counter. It builds one binary
// instance (4x4 bits, DIGIT_MAX=15) and one BCD instance (4x4 bits,
// DIGIT_MAX=9).
//
// Each record holds the inputs for one clock edge and the outputs that
// should appear after that edge. applyStimulus drives a record on the
// falling edge and pushes it onto the scoreboard. checkOutput pops it
// #1 after the rising edge and compares Q/Z/TC/WRAP/HIT.
// ---------------------------------------------------------------------------
module tb_cmp_cascade_counter;
  import cmp_cascade_pkg::*;

  localparam int W = 16;

  logic CK = 1'b0;
  logic rstn_bin;
  logic rstn_bcd;

  cmp_cascade_counter_if #(.W(W)) bin_if ();
  cmp_cascade_counter_if #(.W(W)) bcd_if ();

  cmp_cascade_counter #(.DIGIT_W(4), .DIGITS(4)) dut_bin (
    .CK   (CK),
    .RSTN (rstn_bin),
    .bus  (bin_if.slave)
  );

  cmp_cascade_counter #(.DIGIT_W(4), .DIGITS(4), .DIGIT_MAX(9)) dut_bcd (
    .CK   (CK),
    .RSTN (rstn_bcd),
    .bus  (bcd_if.slave)
  );

  always #5 CK = ~CK;

  typedef struct {
    string        name;
    bit           bcd;
    logic         rstn, en, up, ld;
    logic [W-1:0] ld_val, cmp;
    logic [1:0]   mode;
    logic         clr;
    logic [W-1:0] q;
    logic         z, tc, wrap, hit;
  } vec_t;

  vec_t sb_q[$];
  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(string name, bit bcd,
                              logic rstn, logic en, logic up, logic ld,
                              logic [W-1:0] ld_val, logic [W-1:0] cmp,
                              logic [1:0] mode, logic clr,
                              logic [W-1:0] q, logic z, logic tc,
                              logic wrap, logic hit);
    vec_t v;
    v.name = name; v.bcd = bcd;
    v.rstn = rstn; v.en = en; v.up = up; v.ld = ld;
    v.ld_val = ld_val; v.cmp = cmp; v.mode = mode; v.clr = clr;
    v.q = q; v.z = z; v.tc = tc; v.wrap = wrap; v.hit = hit;
    return v;
  endfunction

  task automatic checkField(input string tag, input string field,
                            input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s %s actual=%h required=%h", tag, field, act, exp);
    end
  endtask

  task automatic checkOutput();
    vec_t         v;
    logic [W-1:0] aq;
    logic         az, atc, awrap, ahit;
    v = sb_q.pop_front();
    if (v.bcd) begin
      aq = bcd_if.Q; az = bcd_if.Z; atc = bcd_if.TC;
      awrap = bcd_if.WRAP; ahit = bcd_if.HIT;
    end else begin
      aq = bin_if.Q; az = bin_if.Z; atc = bin_if.TC;
      awrap = bin_if.WRAP; ahit = bin_if.HIT;
    end
    checkField(v.name, "Q",    aq,          v.q);
    checkField(v.name, "Z",    W'(az),      W'(v.z));
    checkField(v.name, "TC",   W'(atc),     W'(v.tc));
    checkField(v.name, "WRAP", W'(awrap),   W'(v.wrap));
    checkField(v.name, "HIT",  W'(ahit),    W'(v.hit));
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge CK);
    if (v.bcd) begin
      rstn_bcd = v.rstn;
      bcd_if.EN = v.en; bcd_if.UP = v.up; bcd_if.LD = v.ld;
      bcd_if.LD_VAL = v.ld_val; bcd_if.CMP = v.cmp;
      bcd_if.CMP_MODE = v.mode; bcd_if.CLR_HIT = v.clr;
    end else begin
      rstn_bin = v.rstn;
      bin_if.EN = v.en; bin_if.UP = v.up; bin_if.LD = v.ld;
      bin_if.LD_VAL = v.ld_val; bin_if.CMP = v.cmp;
      bin_if.CMP_MODE = v.mode; bin_if.CLR_HIT = v.clr;
    end
    sb_q.push_back(v);
    @(posedge CK);
    #1;
    checkOutput();
  endtask

  // Watchdog so that a broken clock or a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn_bin = 1'b0; rstn_bcd = 1'b0;
    bin_if.EN = 0; bin_if.UP = 0; bin_if.LD = 0; bin_if.LD_VAL = '0;
    bin_if.CMP = '0; bin_if.CMP_MODE = MODE_OFF; bin_if.CLR_HIT = 0;
    bcd_if.EN = 0; bcd_if.UP = 0; bcd_if.LD = 0; bcd_if.LD_VAL = '0;
    bcd_if.CMP = '0; bcd_if.CMP_MODE = MODE_OFF; bcd_if.CLR_HIT = 0;

    //                name          bcd rstn en up ld  ld_val    cmp      mode      clr   q        z  tc wrap hit
    vecs.push_back(mk("reset",       0, 0,  1, 1, 1, 16'h1234, 16'h0000, MODE_OFF, 0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk("ld_fffe",     0, 1,  0, 1, 1, 16'hFFFE, 16'h0000, MODE_OFF, 0, 16'hFFFE, 0, 0, 0, 0));
    vecs.push_back(mk("up_ffff",     0, 1,  1, 1, 0, 16'h0000, 16'h0000, MODE_OFF, 0, 16'hFFFF, 0, 1, 0, 0));
    vecs.push_back(mk("up_wrap",     0, 1,  1, 1, 0, 16'h0000, 16'h0000, MODE_OFF, 0, 16'h0000, 0, 0, 1, 0));
    vecs.push_back(mk("up_0001",     0, 1,  1, 1, 0, 16'h0000, 16'h0000, MODE_OFF, 0, 16'h0001, 0, 0, 0, 0));
    vecs.push_back(mk("ge_ld_00ff",  0, 1,  0, 1, 1, 16'h00FF, 16'h0100, MODE_GE,  1, 16'h00FF, 0, 0, 0, 0));
    vecs.push_back(mk("ge_0100",     0, 1,  1, 1, 0, 16'h0000, 16'h0100, MODE_GE,  0, 16'h0100, 1, 0, 0, 0));
    vecs.push_back(mk("ge_0101",     0, 1,  1, 1, 0, 16'h0000, 16'h0100, MODE_GE,  0, 16'h0101, 1, 0, 0, 1));
    vecs.push_back(mk("le_ld_00ff",  0, 1,  0, 1, 1, 16'h00FF, 16'h0100, MODE_LE,  1, 16'h00FF, 1, 0, 0, 0));
    vecs.push_back(mk("le_0100",     0, 1,  1, 1, 0, 16'h0000, 16'h0100, MODE_LE,  0, 16'h0100, 1, 0, 0, 1));
    vecs.push_back(mk("le_0101",     0, 1,  1, 1, 0, 16'h0000, 16'h0100, MODE_LE,  0, 16'h0101, 0, 0, 0, 1));
    vecs.push_back(mk("off_ld_00ff", 0, 1,  0, 1, 1, 16'h00FF, 16'h0100, MODE_OFF, 1, 16'h00FF, 0, 0, 0, 0));
    vecs.push_back(mk("off_0100",    0, 1,  1, 1, 0, 16'h0000, 16'h0100, MODE_OFF, 0, 16'h0100, 0, 0, 0, 0));
    vecs.push_back(mk("off_0101",    0, 1,  1, 1, 0, 16'h0000, 16'h0100, MODE_OFF, 0, 16'h0101, 0, 0, 0, 0));
    vecs.push_back(mk("ld_ffff",     0, 1,  0, 1, 1, 16'hFFFF, 16'h0000, MODE_OFF, 0, 16'hFFFF, 0, 0, 0, 0));
    vecs.push_back(mk("ld_en_0042",  0, 1,  1, 1, 1, 16'h0042, 16'h0000, MODE_OFF, 0, 16'h0042, 0, 0, 0, 0));
    vecs.push_back(mk("hold_1",      0, 1,  0, 1, 0, 16'h0000, 16'h0000, MODE_OFF, 0, 16'h0042, 0, 0, 0, 0));
    vecs.push_back(mk("hold_2",      0, 1,  0, 1, 0, 16'h0000, 16'h0000, MODE_OFF, 0, 16'h0042, 0, 0, 0, 0));
    vecs.push_back(mk("hold_3",      0, 1,  0, 1, 0, 16'h0000, 16'h0000, MODE_OFF, 0, 16'h0042, 0, 0, 0, 0));
    vecs.push_back(mk("ld_0000",     0, 1,  0, 1, 1, 16'h0000, 16'h0000, MODE_OFF, 0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk("hold_dn_0",   0, 1,  0, 0, 0, 16'h0000, 16'h0000, MODE_OFF, 0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk("flip_dn",     0, 1,  1, 0, 0, 16'h0000, 16'h0000, MODE_OFF, 0, 16'hFFFF, 0, 0, 1, 0));
    vecs.push_back(mk("reset_mid",   0, 0,  1, 0, 1, 16'h1234, 16'h0000, MODE_OFF, 1, 16'h0000, 0, 1, 0, 0));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // EQ compare and sticky HIT behaviour around a single match.
    applyStimulus(mk("eq_ld_000e",  0, 1, 0, 1, 1, 16'h000E, 16'h0010, MODE_EQ, 0, 16'h000E, 0, 0, 0, 0));
    applyStimulus(mk("eq_000f",     0, 1, 1, 1, 0, 16'h0000, 16'h0010, MODE_EQ, 0, 16'h000F, 0, 0, 0, 0));
    applyStimulus(mk("eq_0010",     0, 1, 1, 1, 0, 16'h0000, 16'h0010, MODE_EQ, 0, 16'h0010, 1, 0, 0, 0));
    applyStimulus(mk("eq_hold",     0, 1, 0, 1, 0, 16'h0000, 16'h0010, MODE_EQ, 0, 16'h0010, 1, 0, 0, 1));
    applyStimulus(mk("eq_0011",     0, 1, 1, 1, 0, 16'h0000, 16'h0010, MODE_EQ, 0, 16'h0011, 0, 0, 0, 1));
    applyStimulus(mk("eq_sticky",   0, 1, 1, 1, 0, 16'h0000, 16'h0010, MODE_EQ, 0, 16'h0012, 0, 0, 0, 1));
    applyStimulus(mk("eq_clr",      0, 1, 0, 1, 0, 16'h0000, 16'h0010, MODE_EQ, 1, 16'h0012, 0, 0, 0, 0));
    applyStimulus(mk("eq_ld_0010",  0, 1, 0, 1, 1, 16'h0010, 16'h0010, MODE_EQ, 0, 16'h0010, 1, 0, 0, 0));
    applyStimulus(mk("eq_set_wins", 0, 1, 0, 1, 0, 16'h0000, 16'h0010, MODE_EQ, 1, 16'h0010, 1, 0, 0, 1));
    applyStimulus(mk("eq_set_wins2",0, 1, 0, 1, 0, 16'h0000, 16'h0010, MODE_EQ, 1, 16'h0010, 1, 0, 0, 1));

    // BCD instance: cascade at 9, wrap in both directions, load clamping.
    applyStimulus(mk("bcd_reset",   1, 0, 1, 1, 1, 16'h1234, 16'h0000, MODE_OFF, 0, 16'h0000, 0, 0, 0, 0));
    applyStimulus(mk("bcd_ld_0999", 1, 1, 0, 1, 1, 16'h0999, 16'h0000, MODE_OFF, 0, 16'h0999, 0, 0, 0, 0));
    applyStimulus(mk("bcd_up_1000", 1, 1, 1, 1, 0, 16'h0000, 16'h0000, MODE_OFF, 0, 16'h1000, 0, 0, 0, 0));
    applyStimulus(mk("bcd_ld_0000", 1, 1, 0, 1, 1, 16'h0000, 16'h0000, MODE_OFF, 0, 16'h0000, 0, 0, 0, 0));
    applyStimulus(mk("bcd_dn_9999", 1, 1, 1, 0, 0, 16'h0000, 16'h0000, MODE_OFF, 0, 16'h9999, 0, 0, 1, 0));
    applyStimulus(mk("bcd_up_wrap", 1, 1, 1, 1, 0, 16'h0000, 16'h0000, MODE_OFF, 0, 16'h0000, 0, 0, 1, 0));
    applyStimulus(mk("bcd_clamp",   1, 1, 0, 1, 1, 16'h00A0, 16'h0000, MODE_OFF, 0, 16'h0090, 0, 0, 0, 0));
    applyStimulus(mk("bcd_tc_9999", 1, 1, 1, 1, 1, 16'h9999, 16'h0000, MODE_OFF, 0, 16'h9999, 0, 1, 0, 0));

    checkField("scoreboard", "left", W'(sb_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
